// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and helpers for alu_seq.
// Optional multiplier is enabled with ALU_SEQ_MUL_EN.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational datapath: ADD, SUB, XOR, SLT.
// CarryOut on SUB is the borrow, i.e. inverted carry out of the MSB.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             ovf_o
);
    import alu_seq_pkg::*;

    localparam int M = WIDTH - 1;

    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic           add_ci;
    logic           sub_ci;
    logic           add_of;
    logic           sub_of;

    assign add_w  = {1'b0, a_i} + {1'b0, b_i};
    assign sub_w  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ci = a_i[M] ^ b_i[M] ^ add_w[M];
    assign sub_ci = a_i[M] ^ ~b_i[M] ^ sub_w[M];
    assign add_of = add_ci ^ add_w[WIDTH];
    assign sub_of = sub_ci ^ sub_w[WIDTH];

    always_comb begin
        res_o   = '0;
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                res_o   = add_w[M:0];
                carry_o = add_w[WIDTH];
                ovf_o   = add_of;
            end
            OP_SUB: begin
                res_o   = sub_w[M:0];
                carry_o = ~sub_w[WIDTH];
                ovf_o   = sub_of;
            end
            OP_XOR: res_o = a_i ^ b_i;
            OP_SLT: res_o = {{(WIDTH-1){1'b0}}, sub_w[M] ^ sub_of};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: FSM, bit-serial shifter and optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to enable opcode 111 as MUL; otherwise it returns 0.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] BussA,
    input  logic [WIDTH-1:0] BussB,
    output logic [WIDTH-1:0] Output,
    output logic             CarryOut,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             Busy,
    output logic             Done
);
    import alu_seq_pkg::*;

    state_e state_q, state_d;

    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               sh_en_q, sh_en_d;

    logic [WIDTH-1:0]   res_q, res_d;
    logic               cf_q, cf_d;
    logic               of_q, of_d;
    logic               z_q, z_d;
    logic               n_q, n_d;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   acc_q, acc_d;
`endif

    logic [WIDTH-1:0]   core_res;
    logic               core_cf;
    logic               core_of;
    logic [WIDTH-1:0]   sh_val;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_cf;
    logic               fin_of;
    logic               start_nz;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .res_o  (core_res),
        .carry_o(core_cf),
        .ovf_o  (core_of)
    );

    assign start_nz = |BussB[SHAMT_W-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        sh_en_d = sh_en_q;
        res_d   = res_q;
        cf_d    = cf_q;
        of_d    = of_q;
        z_d     = z_q;
        n_d     = n_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d   = acc_q;
`endif
        sh_val  = a_q;
        fin_res = core_res;
        fin_cf  = core_cf;
        fin_of  = core_of;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_EXEC;
                    op_d    = ALUControl;
                    a_d     = BussA;
                    b_d     = BussB;
                    sh_en_d = start_nz;
                    cnt_d   = '0;
                    // Shift by n costs n cycles; n=0 still takes one.
                    if (is_shift(ALUControl) && start_nz)
                        cnt_d = BussB[SHAMT_W-1:0] - SHAMT_W'(1);
`ifdef ALU_SEQ_MUL_EN
                    if (ALUControl == OP_MUL) begin
                        cnt_d = SHAMT_W'(WIDTH - 1);
                        acc_d = '0;
                    end
`endif
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_SLL, OP_SRL, OP_SRA: begin
                        if (sh_en_q) begin
                            if (op_q == OP_SLL)
                                sh_val = {a_q[WIDTH-2:0], 1'b0};
                            else if (op_q == OP_SRL)
                                sh_val = {1'b0, a_q[WIDTH-1:1]};
                            else
                                sh_val = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                        end
                        a_d     = sh_val;
                        fin_res = sh_val;
                        fin_cf  = 1'b0;
                        fin_of  = 1'b0;
                    end
                    OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                        // a_q is the shifting multiplicand, b_q the multiplier.
                        acc_d   = acc_q + (b_q[0] ? a_q : '0);
                        a_d     = {a_q[WIDTH-2:0], 1'b0};
                        b_d     = {1'b0, b_q[WIDTH-1:1]};
                        fin_res = acc_d;
`else
                        fin_res = '0;
`endif
                        fin_cf  = 1'b0;
                        fin_of  = 1'b0;
                    end
                    default: ;
                endcase
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = fin_res;
                    cf_d    = fin_cf;
                    of_d    = fin_of;
                    z_d     = (fin_res == '0);
                    n_d     = fin_res[WIDTH-1];
                end else begin
                    cnt_d = cnt_q - SHAMT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sh_en_q <= 1'b0;
            res_q   <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sh_en_q <= sh_en_d;
            res_q   <= res_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            z_q     <= z_d;
            n_q     <= n_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign Output   = res_q;
    assign CarryOut = cf_q;
    assign overflow = of_q;
    assign zero     = z_q;
    assign negative = n_q;
    assign Busy     = (state_q == S_EXEC);
    assign Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: random ops vs an arithmetic reference model.
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   ctrl;
    logic [W-1:0] bus_a;
    logic [W-1:0] bus_b;
    logic [W-1:0] dut_out;
    logic         cout;
    logic         ovf;
    logic         zf;
    logic         nf;
    logic         busy;
    logic         done;

    alu_seq #(.WIDTH(W)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start),
        .ALUControl(ctrl),
        .BussA     (bus_a),
        .BussB     (bus_b),
        .Output    (dut_out),
        .CarryOut  (cout),
        .overflow  (ovf),
        .zero      (zf),
        .negative  (nf),
        .Busy      (busy),
        .Done      (done)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         cf;
        logic         of;
        logic         z;
        logic         n;
        int           exec;
        int           t0;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           pass_cnt = 0;
    int           total_cnt = 0;
    int           cyc = 0;
    int           busy_cnt = 0;
    logic [W-1:0] held = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model straight from the opcode definitions.
    function automatic exp_t model(input logic [2:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic [W:0] wide;
        int n;
        n = int'(b[4:0]);
        e.res = '0; e.cf = 0; e.of = 0; e.exec = 1; e.t0 = 0;
        case (op)
            3'b000: begin
                wide = {1'b0, a} + {1'b0, b};
                e.res = wide[W-1:0];
                e.cf = wide[W];
                e.of = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b010: begin
                e.res = a - b;
                e.cf = (a < b);
                e.of = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b001: e.res = a ^ b;
            3'b011: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            3'b100: begin e.res = a << n; e.exec = (n == 0) ? 1 : n; end
            3'b101: begin e.res = a >> n; e.exec = (n == 0) ? 1 : n; end
            3'b110: begin
                e.res = $signed(a) >>> n;
                e.exec = (n == 0) ? 1 : n;
            end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                e.res = a * b;
                e.exec = W;
`else
                e.res = '0;
`endif
            end
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    task automatic scramble();
        ctrl  = 3'($urandom_range(0, 7));
        bus_a = $urandom;
        bus_b = $urandom;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        exp_t e;
        int budget;
        @(negedge clk);
        start = 1'b1; ctrl = op; bus_a = a; bus_b = b;
        e = model(op, a, b);
        e.t0 = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        scramble();
        budget = 0;
        while (!done && budget < 200) begin
            if (busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                scramble();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL timeout: no Done after %0d cycles", budget);
        end
        start = 1'($urandom_range(0, 1));
        scramble();
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: got Done expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", 64'(dut_out), 64'(mon_e.res));
                    chk("carry", 64'(cout), 64'(mon_e.cf));
                    chk("overflow", 64'(ovf), 64'(mon_e.of));
                    chk("zero", 64'(zf), 64'(mon_e.z));
                    chk("negative", 64'(nf), 64'(mon_e.n));
                    chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.exec + 1));
                    chk("busy_cycles", 64'(busy_cnt), 64'(mon_e.exec));
                    held = dut_out;
                end
                busy_cnt = 0;
            end else begin
                chk("hold", 64'(dut_out), 64'(held));
            end
        end
    end

    initial begin
        logic [W-1:0] sp[6];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        sp[0] = 32'h0; sp[1] = 32'hFFFF_FFFF; sp[2] = 32'h7FFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h1; sp[5] = 32'h5;
        rst = 1'b1; start = 1'b0; ctrl = '0; bus_a = '0; bus_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 64'(dut_out), 64'h0);
        chk("rst_zero", 64'(zf), 64'h1);
        chk("rst_flags", 64'({cout, ovf, nf}), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
        issue(3'b010, 32'd5, 32'd5);
        issue(3'b011, 32'hFFFF_FFFF, 32'd1);
        issue(3'b110, 32'h8000_0000, 32'd4);
        issue(3'b100, 32'h1234_5678, 32'd0);
        issue(3'b111, 32'h0000_000F, 32'h0000_0011);
        issue(3'b010, 32'd3, 32'd7);
        issue(3'b001, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        issue(3'b101, 32'h8000_0001, 32'd31);
        issue(3'b011, 32'h8000_0000, 32'h7FFF_FFFF);

        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)]
                                             : W'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)]
                                             : W'($urandom);
            issue(3'($urandom_range(0, 7)), ra, rb);
        end

        // Abort a long op in its third EXEC cycle.
        @(negedge clk);
        start = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        ctrl = 3'b111; bus_a = 32'h0000_00FF; bus_b = 32'h0000_0003;
`else
        ctrl = 3'b101; bus_a = 32'hFFFF_0000; bus_b = 32'd20;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        held = '0;
        exp_q.delete();
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_out", 64'(dut_out), 64'h0);
        chk("abort_zero", 64'(zf), 64'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(3'b000, 32'd40, 32'd2);

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
